// File: rtl/hex_display_writer_if.sv
// Control handshake and Avalon-MM initiator signals for hex_display_writer.
// The master modport is the writer's side; slave is the fabric/testbench side.
interface hex_display_writer_if #(
  parameter int unsigned NUM_DIGITS = 6
);
  logic                    start;
  logic [4*NUM_DIGITS-1:0] value;
  logic                    busy;
  logic                    done;
  logic                    error;
  logic [31:0]             avm_address;
  logic                    avm_write;
  logic [31:0]             avm_writedata;
  logic                    avm_read;
  logic [31:0]             avm_readdata;
  logic                    avm_waitrequest;

  modport master (
    input  start, value, avm_readdata, avm_waitrequest,
    output busy, done, error, avm_address, avm_write, avm_writedata, avm_read
  );

  modport slave (
    output start, value, avm_readdata, avm_waitrequest,
    input  busy, done, error, avm_address, avm_write, avm_writedata, avm_read
  );
endinterface

// File: rtl/hex_display_writer.sv
// Avalon-MM initiator writing 7-segment codes for each nibble of a latched value to HEX PIOs.
// Optional readback check of every digit is enabled by defining HEX_READBACK_VERIFY_EN.
module hex_display_writer #(
  parameter int unsigned NUM_DIGITS  = 6,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] ADDR_STRIDE = 32'h10,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  hex_display_writer_if.master io_bus
);
  localparam int unsigned     ValW    = 4 * NUM_DIGITS;
  localparam int unsigned     IdxW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {StIdle, StWr, StRd, StDone} state_e;

  function automatic logic [6:0] f_seg(input logic [3:0] nib);
    logic [6:0] seg;
    seg = 7'h00;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
    return ACTIVE_LOW ? ~seg : seg;
  endfunction

  state_e            r_state;
  logic [ValW-1:0]   r_value;
  logic [IdxW-1:0]   r_digit;
  logic              r_busy;
  logic              r_done;
  logic              r_write;
  logic [31:0]       r_address;
  logic [31:0]       r_writedata;
`ifdef HEX_READBACK_VERIFY_EN
  logic              r_read;
  logic              r_error;
`endif

  logic [IdxW-1:0]   w_next_digit;
  logic [3:0]        w_next_nibble;
  logic              w_adv;
  logic              w_unused_readdata;

  assign w_next_digit = r_digit + IdxW'(1);

  always_comb begin
    w_next_nibble = 4'h0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (w_next_digit == IdxW'(k)) w_next_nibble = r_value[4*k +: 4];
    end
  end

  // Digit completes on the accept of its last bus phase.
`ifdef HEX_READBACK_VERIFY_EN
  assign w_adv = (r_state == StRd) && !io_bus.avm_waitrequest;
`else
  assign w_adv = (r_state == StWr) && !io_bus.avm_waitrequest;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_value     <= '0;
      r_digit     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_write     <= 1'b0;
      r_address   <= 32'h0;
      r_writedata <= 32'h0;
`ifdef HEX_READBACK_VERIFY_EN
      r_read      <= 1'b0;
      r_error     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (io_bus.start) begin
            r_value     <= io_bus.value;
            r_digit     <= '0;
            r_busy      <= 1'b1;
            r_write     <= 1'b1;
            r_address   <= BASE_ADDR;
            r_writedata <= {25'b0, f_seg(io_bus.value[3:0])};
            r_state     <= StWr;
`ifdef HEX_READBACK_VERIFY_EN
            r_error     <= 1'b0;
`endif
          end
        end
        StWr: begin
          if (!io_bus.avm_waitrequest) begin
            r_write <= 1'b0;
`ifdef HEX_READBACK_VERIFY_EN
            r_read  <= 1'b1;
            r_state <= StRd;
`endif
          end
        end
`ifdef HEX_READBACK_VERIFY_EN
        StRd: begin
          if (!io_bus.avm_waitrequest) begin
            r_read <= 1'b0;
            if (io_bus.avm_readdata[6:0] != r_writedata[6:0]) r_error <= 1'b1;
          end
        end
`endif
        StDone: r_state <= StIdle;
        default: r_state <= StIdle;
      endcase

      // Later assignments override the phase-exit defaults above.
      if (w_adv) begin
        if (r_digit == LastIdx) begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= StDone;
        end else begin
          r_digit     <= w_next_digit;
          r_write     <= 1'b1;
          r_address   <= r_address + ADDR_STRIDE;
          r_writedata <= {25'b0, f_seg(w_next_nibble)};
          r_state     <= StWr;
        end
      end
    end
  end

  assign io_bus.busy          = r_busy;
  assign io_bus.done          = r_done;
  assign io_bus.avm_write     = r_write;
  assign io_bus.avm_address   = r_address;
  assign io_bus.avm_writedata = r_writedata;
`ifdef HEX_READBACK_VERIFY_EN
  assign io_bus.avm_read      = r_read;
  assign io_bus.error         = r_error;
`else
  assign io_bus.avm_read      = 1'b0;
  assign io_bus.error         = 1'b0;
`endif

  assign w_unused_readdata = ^io_bus.avm_readdata;

endmodule

// File: tb/tb_hex_display_writer.sv
// Self-checking bench for hex_display_writer: directed scenarios plus randomized sequences
// checked cycle by cycle against a table-driven reference of the expected bus traffic.
module tb_hex_display_writer;
  localparam int unsigned ND = 6;

  localparam logic [6:0] SEG_HI [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert;
  int   n_fail;

  hex_display_writer_if #(.NUM_DIGITS(ND)) bus ();
  hex_display_writer_if #(.NUM_DIGITS(ND)) bus2 ();

  hex_display_writer #(
    .NUM_DIGITS (ND),
    .BASE_ADDR  (32'h0000_0000),
    .ADDR_STRIDE(32'h10),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .io_bus (bus)
  );

  hex_display_writer #(
    .NUM_DIGITS (ND),
    .BASE_ADDR  (32'h0000_0000),
    .ADDR_STRIDE(32'h10),
    .ACTIVE_LOW (1'b0)
  ) dut_al0 (
    .i_clk  (clk),
    .i_reset(rst),
    .io_bus (bus2)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_wdata(input logic [23:0] v, input int k, input bit al);
    logic [3:0] nib;
    logic [6:0] s;
    nib = 4'(v >> (4 * k));
    s   = SEG_HI[nib];
    if (al) s = ~s;
    return {25'b0, s};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One full update. slow_digit gets exactly slow_n wait cycles on its write, bad_digit
  // returns wrong readback, abort_digit triggers a reset while that digit's write is pending.
  task automatic run_seq(input logic [23:0] val, input int max_wait, input int slow_digit,
                         input int slow_n, input bit hold_start, input int bad_digit,
                         input int abort_digit);
    bit          exp_err;
    logic [31:0] a;
    logic [31:0] d;
    int          nw;
    exp_err = 1'b0;
    chk1("idle_busy", bus.busy, 1'b0);
    bus.value = val;
    bus.start = 1'b1;
    tick();
    if (!hold_start) begin
      bus.start = 1'b0;
      bus.value = 24'($urandom);
    end
    for (int k = 0; k < ND; k++) begin
      a  = 32'(k) * 32'h10;
      d  = ref_wdata(val, k, 1'b1);
      nw = (k == slow_digit) ? slow_n : int'($urandom_range(0, max_wait));
      if (k == abort_digit) begin
        bus.avm_waitrequest = 1'b1;
        chk1("abort_wr", bus.avm_write, 1'b1);
        chk("abort_addr", bus.avm_address, a);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.avm_waitrequest = 1'b0;
        chk1("rst_write", bus.avm_write, 1'b0);
        chk1("rst_busy", bus.busy, 1'b0);
        chk("rst_addr", bus.avm_address, 32'h0);
        chk("rst_wdata", bus.avm_writedata, 32'h0);
        return;
      end
      for (int w = 0; w <= nw; w++) begin
        bus.avm_waitrequest = (w < nw);
        chk1("wr_write", bus.avm_write, 1'b1);
        chk1("wr_read", bus.avm_read, 1'b0);
        chk("wr_addr", bus.avm_address, a);
        chk("wr_data", bus.avm_writedata, d);
        chk1("wr_busy", bus.busy, 1'b1);
        chk1("wr_done", bus.done, 1'b0);
        chk1("wr_error", bus.error, exp_err);
        tick();
      end
`ifdef HEX_READBACK_VERIFY_EN
      nw = int'($urandom_range(0, max_wait));
      for (int w = 0; w <= nw; w++) begin
        bus.avm_waitrequest = (w < nw);
        bus.avm_readdata    = (k == bad_digit) ? 32'h0 : d;
        chk1("rd_read", bus.avm_read, 1'b1);
        chk1("rd_write", bus.avm_write, 1'b0);
        chk("rd_addr", bus.avm_address, a);
        chk1("rd_busy", bus.busy, 1'b1);
        chk1("rd_error", bus.error, exp_err);
        tick();
      end
      if (k == bad_digit) exp_err = 1'b1;
`endif
    end
    bus.avm_waitrequest = 1'b0;
    chk1("done_pulse", bus.done, 1'b1);
    chk1("done_busy", bus.busy, 1'b0);
    chk1("done_write", bus.avm_write, 1'b0);
    chk1("done_read", bus.avm_read, 1'b0);
    chk1("done_error", bus.error, exp_err);
    tick();
    chk1("post_done", bus.done, 1'b0);
    chk1("post_busy", bus.busy, 1'b0);
    chk1("post_write", bus.avm_write, 1'b0);
    bus.start = 1'b0;
    tick();
    chk1("idle_busy2", bus.busy, 1'b0);
    chk1("idle_error", bus.error, exp_err);
  endtask

  initial begin
    int nwr;
    bit seen_done;
    n_assert = 0;
    n_fail   = 0;
    bus.start  = 1'b0;
    bus.value  = '0;
    bus.avm_waitrequest = 1'b0;
    bus.avm_readdata    = 32'h0;
    bus2.start = 1'b0;
    bus2.value = '0;
    bus2.avm_waitrequest = 1'b0;
    bus2.avm_readdata    = 32'h7F;

    rst = 1'b1;
    repeat (3) tick();
    chk1("rst_busy0", bus.busy, 1'b0);
    chk1("rst_done0", bus.done, 1'b0);
    chk1("rst_error0", bus.error, 1'b0);
    chk1("rst_write0", bus.avm_write, 1'b0);
    chk1("rst_read0", bus.avm_read, 1'b0);
    chk("rst_addr0", bus.avm_address, 32'h0);
    chk("rst_wdata0", bus.avm_writedata, 32'h0);
    chk1("rst2_busy0", bus2.busy, 1'b0);
    rst = 1'b0;
    tick();

    // Back-to-back writes, known pattern
    run_seq(24'h012345, 0, -1, 0, 1'b0, -1, -1);
    // Three stall cycles on digit 2
    run_seq(24'hA5C3E1, 0, 2, 3, 1'b0, -1, -1);
    // start held through the sequence
    run_seq(24'h6789AB, 1, -1, 0, 1'b1, -1, -1);
    // Reset mid-sequence, then restart from HEX0
    run_seq(24'hFEDCBA, 0, -1, 0, 1'b0, -1, 3);
    run_seq(24'h13579B, 0, -1, 0, 1'b0, -1, -1);
    // Bad readback on digit 4, then a clean run clears error
    run_seq(24'hFFFFFF, 1, -1, 0, 1'b0, 4, -1);
    run_seq(24'h2468AC, 0, -1, 0, 1'b0, -1, -1);

    for (int i = 0; i < 20; i++) begin
      run_seq(24'($urandom), 3, -1, 0, 1'($urandom_range(0, 1)),
              int'($urandom_range(0, ND)), -1);
    end

    // Active-high segment polarity
    nwr       = 0;
    seen_done = 1'b0;
    bus2.value = 24'h888888;
    bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    for (int c = 0; c < 40 && !seen_done; c++) begin
      if (bus2.avm_write) begin
        chk("al0_wdata", bus2.avm_writedata, 32'h7F);
        chk("al0_addr", bus2.avm_address, 32'(nwr) * 32'h10);
        nwr++;
      end
      if (bus2.done) seen_done = 1'b1;
      tick();
    end
    chk1("al0_done_seen", seen_done, 1'b1);
    chk("al0_nwrites", 32'(nwr), 32'(ND));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
